arbitro_escritura_banco: RTL and testbench
==========================================

ARBITRO_ESCRITURA_BANCO -- requirements
Module: arbitro_escritura_banco

Interface
REQ-001 The block SHALL have parameter PROF, default 2, meaning entries per requester FIFO (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req0_valid, input, 1 and req0_ready, output, 1: requester 0 (ALU writeback) handshake.
REQ-005 The block SHALL have ports req0_addr, input, 5 and req0_data, input, 32: requester 0 destination register and value.
REQ-006 The block SHALL have ports req1_valid, req1_ready, req1_addr and req1_data, with the same directions and widths as requester 0: requester 1 (load unit).
REQ-007 The block SHALL have ports write_enable, output, 1; write_addr, output, 5; and write_data, output, 32: the register-file write port, all registered.
REQ-008 The block SHALL have port busy_mask, output, 32: one bit per register, set while a write to it is pending.

Function
REQ-009 A transfer on requester i SHALL occur on a rising edge where reqi_valid=1 and reqi_ready=1; addr/data are pushed into FIFO i.
REQ-010 reqi_ready SHALL equal (FIFO i not full) AND NOT rst; it SHALL NOT depend on reqi_valid or on a same-cycle pop (full FIFO is never ready).
REQ-011 Each FIFO SHALL preserve its own order; no ordering SHALL be guaranteed between requesters except grant order.
REQ-012 Each cycle with at least one non-empty FIFO, exactly one head entry SHALL be popped (the grant).
REQ-013 Grant rule: only one FIFO non-empty -> grant it; both non-empty -> grant the FIFO not granted last (round robin via a 1-bit last-grant register).
REQ-014 The last-grant register SHALL update on every grant, including grants of x0 entries.
REQ-015 On a grant, the output registers SHALL load write_addr and write_data from the popped entry; write_enable SHALL be 1 if the addr is nonzero, else 0 (x0 writes are consumed and dropped).
REQ-016 In cycles with no grant, write_enable SHALL be 0 and write_addr/write_data SHALL hold their previous values.
REQ-017 Latency: an entry accepted at edge E with both FIFOs otherwise empty SHALL appear on the write port (write_enable=1) after edge E+1; the maximum latency with both FIFOs busy is 2*PROF edges.
REQ-018 An entry pushed on the same edge its FIFO is empty SHALL NOT be granted on that same edge (no pass-through).
REQ-019 busy_mask bit k (k=1..31) SHALL be 1 iff a valid entry in either FIFO has addr k, or write_enable=1 with write_addr=k; bit 0 SHALL always be 0.
REQ-020 busy_mask SHALL be combinational from registered state only (no input-to-output path).

Reset
REQ-021 While rst=1 at an edge: both FIFOs SHALL be emptied; last-grant SHALL be set to 1 (requester 0 wins the first tie); write_enable, write_addr and write_data SHALL become 0.
REQ-022 reset SHALL override any simultaneous push or grant; after reset, busy_mask=0 and reqi_ready=1 once rst falls.
REQ-023 reset mid-operation SHALL discard all pending entries with no write issued.

Verification
REQ-024 Single write: after reset, req0 pushes addr=5, data=0xA5A5A5A5 at edge E -> after E+1: write_enable=1, write_addr=5, write_data=0xA5A5A5A5; after E+2: write_enable=0.
REQ-025 Tie: req0 (addr 3, 0x11) and req1 (addr 4, 0x22) push on the same edge after reset -> addr 3 is written first, addr 4 on the next cycle.
REQ-026 Backpressure: both valid continuously with distinct data, PROF=2 -> grants alternate 0,1,0,1; each reqi_ready drops to 0 when its FIFO holds 2 entries; no entry is lost or duplicated, and per-requester order is preserved.
REQ-027 x0: req1 pushes addr=0, data=0xFFFFFFFF -> it is accepted and the grant occurs, but write_enable stays 0 and busy_mask stays 0.
REQ-028 Scoreboard: req0 pushes addr=7 -> busy_mask=0x00000080 from the edge after the push through the cycle write_enable=1 for addr 7, then 0.
REQ-029 Reset mid-operation: both FIFOs full, rst=1 for one edge -> next cycle write_enable=0, busy_mask=0, both FIFOs empty, no stale write appears afterward.

Source files
------------

// File: rtl/arbitro_escritura_banco.sv
// Register-file write-port arbiter: two requester FIFOs (ALU, load unit) merged
// round-robin onto one registered write port, with a pending-write busy mask.
module arbitro_escritura_banco #(
  parameter int unsigned PROF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        write_enable,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic [31:0] busy_mask
);

  localparam int unsigned AW = (PROF > 1) ? $clog2(PROF) : 1;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [4:0]  addr_q [2][PROF];
  logic [31:0] data_q [2][PROF];
  ptr_t        wr_q   [2];
  ptr_t        rd_q   [2];
  cnt_t        cnt_q  [2];
  logic        last_q;

  logic [4:0]  in_addr [2];
  logic [31:0] in_data [2];
  logic [1:0]  nonempty, full, push, pop;
  logic        gnt_any, gnt_sel;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  always_comb begin
    in_addr[0] = req0_addr;
    in_addr[1] = req1_addr;
    in_data[0] = req0_data;
    in_data[1] = req1_data;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      full[i]     = (cnt_q[i] == cnt_t'(PROF));
    end
    // Ready comes from registered occupancy only, so a full FIFO never accepts.
    req0_ready = !full[0] && !rst;
    req1_ready = !full[1] && !rst;
    push[0]    = req0_valid && req0_ready;
    push[1]    = req1_valid && req1_ready;
    gnt_any    = |nonempty;
    // last_q==1 means requester 1 won last, so requester 0 takes a tie.
    gnt_sel    = nonempty[1] && (!nonempty[0] || !last_q);
    pop[0]     = gnt_any && !gnt_sel;
    pop[1]     = gnt_any && gnt_sel;
    head_addr  = addr_q[gnt_sel][rd_q[gnt_sel]];
    head_data  = data_q[gnt_sel][rd_q[gnt_sel]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      last_q       <= 1'b1;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          addr_q[i][wr_q[i]] <= in_addr[i];
          data_q[i][wr_q[i]] <= in_data[i];
          wr_q[i]            <= wr_q[i] + ptr_t'(1);
        end
        if (pop[i]) rd_q[i] <= rd_q[i] + ptr_t'(1);
        cnt_q[i] <= cnt_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
      end
      if (gnt_any) begin
        write_enable <= (head_addr != 5'd0);
        write_addr   <= head_addr;
        write_data   <= head_data;
        last_q       <= gnt_sel;
      end else begin
        write_enable <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < PROF; j++) begin
        if (cnt_t'(j) < cnt_q[i]) begin
          busy_mask[addr_q[i][rd_q[i] + ptr_t'(j)]] = 1'b1;
        end
      end
    end
    if (write_enable) busy_mask[write_addr] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Randomized scoreboard bench for arbitro_escritura_banco against a queue-based model.
module tb_arbitro_escritura_banco;

  localparam int unsigned PROF = 2;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] busy_mask;

  arbitro_escritura_banco #(.PROF(PROF)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .busy_mask    (busy_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  // Reference model state
  ent_t        mq0[$];
  ent_t        mq1[$];
  ent_t        exp_q[$];
  logic        mlast;
  logic        mwe;
  logic [4:0]  maddr;
  logic [31:0] mdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    foreach (mq0[i]) m[mq0[i].a] = 1'b1;
    foreach (mq1[i]) m[mq1[i].a] = 1'b1;
    if (mwe) m[maddr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of stimulus; the model advances by the same edge.
  task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic r);
    bit   rdy0, rdy1;
    ent_t e;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    rdy0 = (mq0.size() < PROF) && !r;
    rdy1 = (mq1.size() < PROF) && !r;
    if (mon_en) begin
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, rdy0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, rdy1});
    end
    @(posedge clk);
    if (r) begin
      mq0.delete(); mq1.delete();
      mlast = 1'b1; mwe = 1'b0; maddr = '0; mdata = '0;
    end else begin
      if (mq0.size() > 0 || mq1.size() > 0) begin
        if (mq1.size() > 0 && (mq0.size() == 0 || mlast == 1'b0)) begin
          e = mq1.pop_front(); mlast = 1'b1;
        end else begin
          e = mq0.pop_front(); mlast = 1'b0;
        end
        mwe = (e.a != 5'd0); maddr = e.a; mdata = e.d;
        if (mwe) exp_q.push_back(e);
      end else begin
        mwe = 1'b0;
      end
      if (v0 && rdy0) mq0.push_back('{a: a0, d: d0});
      if (v1 && rdy1) mq1.push_back('{a: a1, d: d1});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  // Monitor: cycle-level port checks plus in-order scoreboard of issued writes.
  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      chk("write_enable", {31'b0, write_enable}, {31'b0, mwe});
      chk("write_addr", {27'b0, write_addr}, {27'b0, maddr});
      chk("write_data", write_data, mdata);
      chk("busy_mask", busy_mask, model_busy());
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_write actual=addr %0d required=no write", write_addr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", {27'b0, write_addr}, {27'b0, e.a});
          chk("sb_data", write_data, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    do_reset();
    do_reset();
    mon_en = 1'b1;
    idle(2);

    // single write
    do_reset();
    cycle(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(4);

    // tie after reset: requester 0 first
    do_reset();
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
    idle(4);

    // backpressure, both always valid
    do_reset();
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 5'(8 + i), 32'h1000 + i, 1'b1, 5'(20 + (i % 10)), 32'h2000 + i, 1'b0);
    idle(6);

    // x0 write is consumed but never issued
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    idle(3);

    // busy bit for addr 7
    cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(3);

    // reset with both FIFOs full
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'(1 + i), 32'h3000 + i, 1'b1, 5'(10 + i), 32'h4000 + i, 1'b0);
    do_reset();
    idle(5);

    // randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 9)), $urandom,
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 79) == 0));
    end
    idle(2 * PROF + 4);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
